// File: rtl/dmem_resp_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: byte/half/word loads and stores on a word RAM after WAIT_CYCLES wait states.
// Define DMEM_ERR_EN to flag misaligned, illegal-size and out-of-range accesses on rsp_err.
module dmem_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_resp_if.slave bus
);
    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic                  acc_fire, acc_we, acc_uns, acc_err;
    logic [31:0]           acc_addr, acc_wdata;
    logic [1:0]            acc_size, eff_size, lane;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_lanes, rd_word, rd_shift, load_val;

    // A zero-wait accept performs the access straight from the bus; otherwise use the captured request.
    always_comb begin
        acc_fire  = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_size  = size_q;
        acc_uns   = unsigned_q;
        if (state_q == S_IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_size  = bus.req_size;
            acc_uns   = bus.req_unsigned;
            acc_fire  = bus.req_valid && (WAIT_CYCLES == 0);
        end else if (state_q == S_WAIT) begin
            acc_fire  = (cnt_q == 4'd0);
        end
    end

    always_comb begin
`ifdef DMEM_ERR_EN
        eff_size = acc_size;
        lane     = acc_addr[1:0];
        acc_err  = (acc_size == 2'b11)
                || (acc_size == 2'b01 && acc_addr[0])
                || (acc_size == 2'b10 && acc_addr[1:0] != 2'b00)
                || (acc_addr[31:ADDR_WIDTH+2] != '0);
`else
        eff_size = (acc_size == 2'b11) ? 2'b10 : acc_size;
        acc_err  = 1'b0;
        case (eff_size)
            2'b00:   lane = acc_addr[1:0];
            2'b01:   lane = {acc_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
`endif
    end

`ifndef DMEM_ERR_EN
    logic unused_high_addr;
    assign unused_high_addr = ^acc_addr[31:ADDR_WIDTH+2];
`endif

    assign word_idx = acc_addr[ADDR_WIDTH+1:2];

    always_comb begin
        byte_en     = 4'b1111;
        wdata_lanes = acc_wdata;
        case (eff_size)
            2'b00: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = 4'b0011 << lane;
                wdata_lanes = {2{acc_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        load_val = rd_shift;
        case (eff_size)
            2'b00:   load_val = {{24{~acc_uns & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = {{16{~acc_uns & rd_shift[15]}}, rd_shift[15:0]};
            default: ;
        endcase
    end

    // RAM is not reset; gating on rst_n keeps a reset-abandoned access from writing.
    always_ff @(posedge clk) begin
        if (rst_n && acc_fire && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d       = bus.req_we;
                    addr_d     = bus.req_addr;
                    wdata_d    = bus.req_wdata;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    cnt_d      = WAIT_LOAD;
                    state_d    = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (acc_fire) begin
            err_d   = acc_err;
            rdata_d = (acc_we || acc_err) ? 32'd0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed scenarios plus randomized traffic against a byte-array reference model.
module tb_dmem_resp;
    localparam int ADDR_WIDTH  = 10;
    localparam int WAIT_CYCLES = 1;
    localparam int DEPTH       = 2 ** ADDR_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] lastData;
    logic        lastErr;

    // Reference memory, one entry per byte address
    logic [7:0] refMem [4*DEPTH];

    dmem_resp_if bus ();

    dmem_resp #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Load/store semantics straight from the byte-addressed rules
    function automatic void modelAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [1:0] size, input logic uns,
                                        output logic [31:0] expData, output logic expErr);
        int nBytes;
        int a;
        logic [31:0] val;
        expData = 32'd0;
        expErr  = 1'b0;
`ifdef DMEM_ERR_EN
        if (size == 2'd3) begin
            expErr = 1'b1;
            return;
        end
        nBytes = 1 << size;
        if ((addr % 32'(nBytes)) != 0 || addr >= 32'(4*DEPTH)) begin
            expErr = 1'b1;
            return;
        end
        a = int'(addr);
`else
        nBytes = (size == 2'd3) ? 4 : (1 << size);
        a = int'(addr % 32'(4*DEPTH));
        a = a - (a % nBytes);
`endif
        if (we) begin
            for (int i = 0; i < nBytes; i++) refMem[a+i] = wdata[8*i +: 8];
            return;
        end
        val = 32'd0;
        for (int i = 0; i < nBytes; i++) val[8*i +: 8] = refMem[a+i];
        if (!uns && nBytes < 4 && val[8*nBytes-1]) val = val | (32'hFFFF_FFFF << (8*nBytes));
        expData = val;
    endfunction

    task automatic sendRequest(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns);
        int guard = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // One full transaction; optional junk requests while busy must be ignored
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns, input int hold,
                                 input logic noise, input string tag);
        logic [31:0] expData;
        logic        expErr;
        int          lat;
        modelAccess(we, addr, wdata, size, uns, expData, expErr);
        sendRequest(we, addr, wdata, size, uns);
        if (noise) begin
            bus.req_we    = 1'b1;
            bus.req_addr  = $urandom & 32'h0000_00FC;
            bus.req_wdata = $urandom;
            bus.req_size  = 2'd2;
            bus.req_valid = 1'b1;
        end
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES));
        lastData = bus.rsp_rdata;
        lastErr  = bus.rsp_err;
        for (int h = 0; h <= hold; h++) begin
            checkOutput({tag, "_rdata"}, bus.rsp_rdata, expData);
            checkOutput({tag, "_err"}, 32'(bus.rsp_err), 32'(expErr));
            checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            checkOutput({tag, "_req_ready_busy"}, 32'(bus.req_ready), 32'd0);
            if (h < hold) begin
                @(posedge clk);
                #1;
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        checkOutput({tag, "_req_ready_after"}, 32'(bus.req_ready), 32'd1);
        checkOutput({tag, "_rsp_valid_after"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rAddr;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_size     = '0;
        bus.req_unsigned = 1'b0;
        bus.rsp_ready    = 1'b0;
        rst_n            = 1'b0;
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Give every byte the random traffic can reach a known value
        for (int w = 0; w < 64; w++) applyStimulus(1'b1, 32'(w*4), $urandom, 2'd2, 1'b0, 0, 1'b0, "preload");

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0, "st_word_10");
        applyStimulus(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1'b0, "ld_word_10");
        checkOutput("ld_word_10_const", lastData, 32'hDEADBEEF);

        applyStimulus(1'b1, 32'h20, 32'h0, 2'd2, 1'b0, 0, 1'b0, "st_word_20");
        applyStimulus(1'b1, 32'h21, 32'h12345680, 2'd0, 1'b0, 0, 1'b0, "st_byte_21");
        applyStimulus(1'b0, 32'h21, 32'h0, 2'd0, 1'b0, 0, 1'b0, "ld_sbyte_21");
        checkOutput("ld_sbyte_21_const", lastData, 32'hFFFFFF80);
        applyStimulus(1'b0, 32'h21, 32'h0, 2'd0, 1'b1, 0, 1'b0, "ld_ubyte_21");
        checkOutput("ld_ubyte_21_const", lastData, 32'h00000080);
        applyStimulus(1'b0, 32'h20, 32'h0, 2'd2, 1'b1, 0, 1'b0, "ld_word_20");
        checkOutput("ld_word_20_const", lastData, 32'h00008000);

        applyStimulus(1'b1, 32'h30, 32'h11223344, 2'd2, 1'b0, 0, 1'b0, "st_word_30");
        applyStimulus(1'b1, 32'h32, 32'hFFFFA55A, 2'd1, 1'b0, 0, 1'b0, "st_half_32");
        applyStimulus(1'b0, 32'h32, 32'h0, 2'd1, 1'b0, 0, 1'b0, "ld_shalf_32");
        checkOutput("ld_shalf_32_const", lastData, 32'hFFFFA55A);
        applyStimulus(1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 0, 1'b0, "ld_word_30");
        checkOutput("ld_word_30_const", lastData, 32'hA55A3344);

        applyStimulus(1'b0, 32'h13, 32'h0, 2'd2, 1'b0, 0, 1'b0, "ld_word_13");
        applyStimulus(1'b1, 32'h1000, 32'h5A5A5A5A, 2'd2, 1'b0, 0, 1'b0, "st_word_1000");
`ifdef DMEM_ERR_EN
        checkOutput("st_word_1000_err_const", 32'(lastErr), 32'd1);
`else
        checkOutput("st_word_1000_err_const", 32'(lastErr), 32'd0);
`endif
        applyStimulus(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, 1'b0, "ld_word_0");

        // Response held off for five cycles
        applyStimulus(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5, 1'b1, "hold_ld_10");

        // Reset during the wait state of a store must leave the old word intact
        applyStimulus(1'b1, 32'h40, 32'hCAFEF00D, 2'd2, 1'b0, 0, 1'b0, "st_old_40");
        sendRequest(1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0);
        checkOutput("rst_wait_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_mid_rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("rst_mid_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, 1'b0, "ld_after_rst_40");
        checkOutput("ld_after_rst_40_const", lastData, 32'hCAFEF00D);

        for (int n = 0; n < 150; n++) begin
            rAddr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) rAddr = rAddr | ($urandom << 12);
            applyStimulus(1'($urandom), rAddr, $urandom, 2'($urandom_range(0, 3)), 1'($urandom),
                          $urandom_range(0, 3), 1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
